univ_shift_reg: RTL and testbench

//  Parametrised WIDTH-bit register built from D-type storage with synchronous reset,

---
 rtl/shr_pkg.sv | 23 ++
 rtl/univ_shift_reg.sv | 103 ++++++++++
 tb/tb_univ_shift_reg.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/shr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// serialiser state encoding.
package shr_pkg;

   localparam int unsigned MODE_W = 3;

   // Operation select, sampled when en=1 and the serialiser is idle
   localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
   localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
   localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
   localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
   localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
   localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
   localparam logic [MODE_W-1:0] MODE_SER  = 3'b110;
   localparam logic [MODE_W-1:0] MODE_RSVD = 3'b111;

   // One-bit encoding so busy is the state flop itself
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SER  = 1'b1
   } shr_state_e;

endpackage : shr_pkg

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register with hold/load/shift/rotate modes and an
// autonomous LSB-first serialiser.
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous active-high reset, overrides everything
//   en      - clock enable; freezes q, state and counter (done still clears)
//   mode    - operation select (shr_pkg MODE_*), honoured only while idle
//   d       - parallel load data
//   sil     - bit entering q[0] on shift-left
//   sir     - bit entering q[WIDTH-1] on shift-right and while serialising
//   q       - register contents
//   qbar    - ~q
//   ser_out - q[0]
//   busy    - serialiser active
//   done    - one-cycle pulse after the last serialised bit
module univ_shift_reg
   import shr_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              en,
   input  logic [2:0]        mode,
   input  logic [WIDTH-1:0]  d,
   input  logic              sil,
   input  logic              sir,
   output logic [WIDTH-1:0]  q,
   output logic [WIDTH-1:0]  qbar,
   output logic              ser_out,
   output logic              busy,
   output logic              done
);

   localparam int unsigned       CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   shr_state_e       state_q, state_d;
   logic             done_q, done_d;

   // Next-state logic for register, FSM, bit counter and done pulse
   always_comb begin
      q_d     = q_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      done_d  = 1'b0;
      if (en) begin
         case (state_q)
            ST_IDLE: begin
               case (mode)
                  MODE_LOAD: q_d = d;
                  MODE_SHL:  q_d = {q_q[WIDTH-2:0], sil};
                  MODE_SHR:  q_d = {sir, q_q[WIDTH-1:1]};
                  MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                  MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                  MODE_SER: begin
                     q_d     = d;
                     cnt_d   = '0;
                     state_d = ST_SER;
                  end
                  default:   q_d = q_q;
               endcase
            end
            ST_SER: begin
               q_d   = {sir, q_q[WIDTH-1:1]};
               cnt_d = cnt_q + CNT_W'(1);
               // Last bit leaves on this edge; explicit clear covers non-power-of-2 widths
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State registers
   always_ff @(posedge clock) begin
      if (reset) begin
         q_q     <= RESET_VAL;
         cnt_q   <= '0;
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
      end else begin
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   assign q       = q_q;
   assign qbar    = ~q_q;
   assign ser_out = q_q[0];
   assign busy    = (state_q == ST_SER);
   assign done    = done_q;

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed vector table, hand-written
// serialiser sequences, and random stimulus against a reference model.
module tb_univ_shift_reg;

   localparam int unsigned W = 8;

   logic         clock = 1'b0;
   logic         reset, en, sil, sir;
   logic [2:0]   mode;
   logic [W-1:0] d;

   logic [W-1:0] q0, qb0, q1, qb1;
   logic         so0, b0, dn0, so1, b1, dn1;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: one slot per DUT, values as plain integers
   int rv     [2] = '{0, 'hA5};
   int m_q    [2];
   int m_left [2];   // serialiser edges remaining
   int m_done [2];

   univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
      .clock(clock), .reset(reset), .en(en), .mode(mode), .d(d),
      .sil(sil), .sir(sir), .q(q0), .qbar(qb0), .ser_out(so0),
      .busy(b0), .done(dn0));

   univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'hA5)) dut_a5 (
      .clock(clock), .reset(reset), .en(en), .mode(mode), .d(d),
      .sil(sil), .sir(sir), .q(q1), .qbar(qb1), .ser_out(so1),
      .busy(b1), .done(dn1));

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      else
         n_pass++;
   endtask

   // Advance the model by one rising edge using the current inputs
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_q[i] = rv[i]; m_left[i] = 0; m_done[i] = 0;
         end else begin
            int nd = 0;
            if (en) begin
               if (m_left[i] > 0) begin
                  m_q[i] = m_q[i] / 2 + (sir ? 128 : 0);
                  m_left[i]--;
                  if (m_left[i] == 0) nd = 1;
               end else begin
                  case (mode)
                     3'd1: m_q[i] = int'(d);
                     3'd2: m_q[i] = (m_q[i] * 2 + (sil ? 1 : 0)) % 256;
                     3'd3: m_q[i] = m_q[i] / 2 + (sir ? 128 : 0);
                     3'd4: m_q[i] = (m_q[i] * 2) % 256 + m_q[i] / 128;
                     3'd5: m_q[i] = m_q[i] / 2 + (m_q[i] % 2) * 128;
                     3'd6: begin m_q[i] = int'(d); m_left[i] = W; end
                     default: ;
                  endcase
               end
            end
            m_done[i] = nd;
         end
      end
   endtask

   task automatic check_model();
      chk("q0",       q0,  8'(m_q[0]));
      chk("qbar0",    qb0, 8'(255 - m_q[0]));
      chk("ser_out0", 8'(so0), 8'(m_q[0] % 2));
      chk("busy0",    8'(b0),  8'(m_left[0] > 0));
      chk("done0",    8'(dn0), 8'(m_done[0]));
      chk("q1",       q1,  8'(m_q[1]));
      chk("qbar1",    qb1, 8'(255 - m_q[1]));
      chk("busy1",    8'(b1),  8'(m_left[1] > 0));
      chk("done1",    8'(dn1), 8'(m_done[1]));
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
      check_model();
   endtask

   task automatic drive(input logic r, input logic e, input logic [2:0] m,
                        input logic [7:0] dd, input logic sl, input logic sr);
      reset = r; en = e; mode = m; d = dd; sil = sl; sir = sr;
   endtask

   typedef struct {
      logic       rst;
      logic       en;
      logic [2:0] mode;
      logic [7:0] d;
      logic       sil;
      logic       sir;
      logic [7:0] exp_q;
      logic       exp_so;
      logic       exp_busy;
      logic       exp_done;
   } vec_t;

   vec_t vt[26];

   initial begin : main
      int busy_cyc, nbits, ndone;
      logic [7:0] bits;

      drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin m_q[i] = 0; m_left[i] = 0; m_done[i] = 0; end

      // rst en mode d sil sir | q ser_out busy done
      vt[0]  = '{1, 0, 3'd0, 8'h00, 0, 0, 8'h00, 0, 0, 0};
      vt[1]  = '{0, 1, 3'd1, 8'h96, 0, 0, 8'h96, 0, 0, 0};
      vt[2]  = '{0, 1, 3'd2, 8'h00, 1, 0, 8'h2D, 1, 0, 0};
      vt[3]  = '{0, 1, 3'd2, 8'h00, 1, 0, 8'h5B, 1, 0, 0};
      vt[4]  = '{0, 1, 3'd3, 8'h00, 0, 0, 8'h2D, 1, 0, 0};
      vt[5]  = '{0, 1, 3'd1, 8'h81, 0, 0, 8'h81, 1, 0, 0};
      vt[6]  = '{0, 1, 3'd4, 8'h00, 0, 0, 8'h03, 1, 0, 0};
      vt[7]  = '{0, 1, 3'd5, 8'h00, 0, 0, 8'h81, 1, 0, 0};
      vt[8]  = '{0, 1, 3'd5, 8'h00, 0, 0, 8'hC0, 0, 0, 0};
      vt[9]  = '{0, 0, 3'd4, 8'h00, 0, 0, 8'hC0, 0, 0, 0};
      vt[10] = '{0, 0, 3'd4, 8'h00, 0, 0, 8'hC0, 0, 0, 0};
      vt[11] = '{0, 0, 3'd4, 8'h00, 0, 0, 8'hC0, 0, 0, 0};
      vt[12] = '{0, 1, 3'd7, 8'h12, 1, 1, 8'hC0, 0, 0, 0};
      vt[13] = '{0, 1, 3'd0, 8'h34, 1, 1, 8'hC0, 0, 0, 0};
      vt[14] = '{0, 1, 3'd6, 8'hB4, 0, 0, 8'hB4, 0, 1, 0};
      vt[15] = '{0, 1, 3'd0, 8'h00, 0, 0, 8'h5A, 0, 1, 0};
      vt[16] = '{0, 1, 3'd0, 8'h00, 0, 0, 8'h2D, 1, 1, 0};
      vt[17] = '{0, 1, 3'd6, 8'hFF, 0, 0, 8'h16, 0, 1, 0};
      vt[18] = '{0, 1, 3'd1, 8'hFF, 0, 0, 8'h0B, 1, 1, 0};
      vt[19] = '{0, 1, 3'd0, 8'h00, 0, 0, 8'h05, 1, 1, 0};
      vt[20] = '{0, 1, 3'd0, 8'h00, 0, 0, 8'h02, 0, 1, 0};
      vt[21] = '{0, 1, 3'd0, 8'h00, 0, 0, 8'h01, 1, 1, 0};
      vt[22] = '{0, 1, 3'd0, 8'h00, 0, 0, 8'h00, 0, 0, 1};
      vt[23] = '{0, 0, 3'd1, 8'h3C, 0, 0, 8'h00, 0, 0, 0};
      vt[24] = '{0, 1, 3'd1, 8'h3C, 0, 0, 8'h3C, 0, 0, 0};
      vt[25] = '{1, 1, 3'd1, 8'h55, 0, 0, 8'h00, 0, 0, 0};

      for (int i = 0; i < 26; i++) begin
         drive(vt[i].rst, vt[i].en, vt[i].mode, vt[i].d, vt[i].sil, vt[i].sir);
         tick();
         chk($sformatf("vec%0d_q", i),    q0,        vt[i].exp_q);
         chk($sformatf("vec%0d_qbar", i), qb0,       ~vt[i].exp_q);
         chk($sformatf("vec%0d_so", i),   8'(so0),   8'(vt[i].exp_so));
         chk($sformatf("vec%0d_busy", i), 8'(b0),    8'(vt[i].exp_busy));
         chk($sformatf("vec%0d_done", i), 8'(dn0),   8'(vt[i].exp_done));
      end
      // RESET_VAL=A5 instance after the reset in the last row
      chk("a5_reset_q",    q1,  8'hA5);
      chk("a5_reset_qbar", qb1, 8'h5A);

      // Serialise FF with en toggling; a mid-stream 110 with d=00 must be ignored
      drive(1'b0, 1'b1, 3'd6, 8'hFF, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
      busy_cyc = 0; nbits = 0; ndone = 0; bits = '0;
      for (int i = 0; i < 40; i++) begin
         en   = i[0];
         mode = (i == 5) ? 3'd6 : 3'd0;
         if (b0) begin
            busy_cyc++;
            if (en) begin
               if (nbits < 8) bits[nbits] = so0;
               nbits++;
            end
         end
         tick();
         if (dn0) ndone++;
      end
      chk("ser_en_toggle_busy_cycles", 8'(busy_cyc), 8'd16);
      chk("ser_en_toggle_nbits",       8'(nbits),    8'd8);
      chk("ser_en_toggle_bits",        bits,         8'hFF);
      chk("ser_en_toggle_done_pulses", 8'(ndone),    8'd1);

      // Reset at busy cycle 3 aborts with no done pulse; LOAD afterwards works
      drive(1'b0, 1'b1, 3'd6, 8'hC3, 1'b0, 1'b1);
      tick();
      mode = 3'd0;
      for (int i = 0; i < 3; i++) tick();
      chk("abort_busy_before", 8'(b0), 8'd1);
      reset = 1'b1;
      tick();
      chk("abort_q",    q0, 8'h00);
      chk("abort_busy", 8'(b0), 8'd0);
      chk("abort_q_a5", q1, 8'hA5);
      reset = 1'b0;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (dn0 || dn1) ndone++;
      end
      chk("abort_no_done", 8'(ndone), 8'd0);
      drive(1'b0, 1'b1, 3'd1, 8'h5A, 1'b0, 1'b0);
      tick();
      chk("abort_then_load", q0, 8'h5A);

      // Random stimulus against the model
      for (int i = 0; i < 2000; i++) begin
         reset = ($urandom_range(63) == 0);
         en    = ($urandom_range(3) != 0);
         mode  = 3'($urandom_range(7));
         d     = 8'($urandom);
         sil   = 1'($urandom);
         sir   = 1'($urandom);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_univ_shift_reg
